sector_timer: RTL
=================

Name: sector_timer

Overview:
- Parametrised successor to the fixed 16-sector, 2.5 MHz disk sector counter. Generates sector and index strobes plus the current sector number for an emulated drive.
- Adds:
  - configurable sectors per track, sector period and strobe width
  - enable-driven spin-up state machine with a ready flag
  - target-sector match detection for the controller read/write path
- Sits between the drive clock domain and the controller interface logic.

Parameters:
- SECTORS, 16: sectors per revolution; legal range 2..2^SECTOR_W.
- SECTOR_W, 5: width of the sector output.
- SECTOR_CLKS, 3906: clk2_5 cycles per sector.
- STROBE_CLKS, 120: sector strobe width in cycles (48 us at 2.5 MHz); must be < SECTOR_CLKS.
- CNT_W, 12: width of the intra-sector counter; 2^CNT_W must be >= SECTOR_CLKS+8.
- SPINUP_REVS, 2: full revolutions counted before ready.

Ports:
- clk2_5  in  1  2.5 MHz drive clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  drive enable (motor on).
- target_sector  in  SECTOR_W  sector the controller wants.
- ready  out  1  drive up to speed; strobes valid.
- index_strobe  out  1  sector strobe during sector 0.
- sector_strobe  out  1  strobe at start of each sector.
- sector  out  SECTOR_W  current sector number.
- sector_match  out  1  1-cycle pulse when sector advances to target_sector.
- at_target  out  1  level: sector == target_sector while ready.
- sector_phase  out  CNT_W  intra-sector counter value.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, sector=0, rev count=0. All outputs 0.
- States:
  - IDLE: counter and sector held at 0.
  - SPINUP: counter and sector run; all strobes and match outputs forced 0.
  - READY: full operation.
- Transitions:
  - IDLE->SPINUP on clock edge with en=1.
  - SPINUP->READY on the edge where the SPINUP_REVS-th revolution completes. Counter and sector wrap to 0 on that same edge.
  - Any state->IDLE on the first edge with en=0: counter, sector and rev count cleared; strobes drop the next cycle.
- Counter:
  - Counts 0..P-1, where P = sector period (SECTOR_CLKS unless trimmed).
  - At counter==P-1: counter->0 and sector advances.
  - Sector wraps SECTORS-1 -> 0; no value >= SECTORS is ever output.
- Revolution complete: counter==P-1 and sector==SECTORS-1. The rev count saturates at SPINUP_REVS.
- Strobes are registered, one cycle latency from counter state:
  - sector_strobe(t+1) = (state==READY) && counter(t) < STROBE_CLKS.
  - index_strobe(t+1) = the same term && sector(t)==0.
- ready is registered and equals (state==READY).
- sector_match:
  - Asserts for one cycle on the cycle after a sector advance where the new sector == target_sector, in READY only.
  - Also fires on the READY entry edge if target_sector==0.
  - A target_sector change mid-sector does not generate a pulse.
- at_target: combinational compare of the registered sector and target_sector, gated by ready.
- target_sector >= SECTORS: never matches; no error.
- en toggling low then high mid-spin-up: spin-up restarts from 0 revolutions.

Optional Feature:
- Macro: SECTOR_TIMER_SPEED_TRIM_EN.
- With the macro defined:
  - Adds input speed_trim, signed 4 bits.
  - P = SECTOR_CLKS + speed_trim, sampled into a register only when counter wraps (and on IDLE->SPINUP).
  - P stays constant within a sector, and strobe width is unaffected.
- Without the macro: the port is absent and P = SECTOR_CLKS as a constant.

Test Plan:
1. Reset mid-READY (rst_n low asynchronously at an arbitrary point) -> all outputs 0 immediately. After release with en=0, state stays IDLE and sector=0.
2. Spin-up (defaults; en rises at cycle 0) -> ready rises 124992 cycles later. No strobes before that. sector_strobe and index_strobe are high for exactly 120 cycles starting 1 cycle after ready.
3. Steady state -> sector_strobe period is 3906 cycles, sector runs 0..15 then wraps to 0, and index_strobe occurs once per 62496 cycles.
4. target_sector=5 in READY -> sector_match is a single-cycle pulse 1 cycle after sector becomes 5, and at_target is high for 3906 cycles. target_sector=17 -> no match ever.
5. en drops during sector 9 -> next cycle ready=0, sector=0, and strobes clear. en reasserted -> full 2-revolution spin-up repeats.
6. SECTORS=12, SECTOR_W=4 build -> sector wraps 11->0. With SECTOR_TIMER_SPEED_TRIM_EN and speed_trim=-3, the period becomes 3903, applied from the next sector boundary.

Source files
------------

// File: rtl/sector_timer.sv
// Sector/index strobe generator for an emulated drive with spin-up sequencing and target match.
// Optional SECTOR_TIMER_SPEED_TRIM_EN adds a signed per-sector period trim input.
`timescale 1ns/1ps
module sector_timer #(
    parameter int SECTORS     = 16,
    parameter int SECTOR_W    = 5,
    parameter int SECTOR_CLKS = 3906,
    parameter int STROBE_CLKS = 120,
    parameter int CNT_W       = 12,
    parameter int SPINUP_REVS = 2
) (
    input  logic                clk2_5,
    input  logic                rst_n,
    input  logic                en,
`ifdef SECTOR_TIMER_SPEED_TRIM_EN
    input  logic signed [3:0]   speed_trim,
`endif
    input  logic [SECTOR_W-1:0] target_sector,
    output logic                ready,
    output logic                index_strobe,
    output logic                sector_strobe,
    output logic [SECTOR_W-1:0] sector,
    output logic                sector_match,
    output logic                at_target,
    output logic [CNT_W-1:0]    sector_phase
);

    localparam int REV_W = (SPINUP_REVS < 2) ? 1 : $clog2(SPINUP_REVS + 1);

    typedef enum logic [1:0] {IDLE, SPINUP, READY} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [REV_W-1:0]    rev_cnt;
    logic [CNT_W-1:0]    p_last;
    logic                wrap;
    logic                sec_last;
    logic                rev_done;
    logic                spin_done;
    logic [SECTOR_W-1:0] sector_nxt;

`ifdef SECTOR_TIMER_SPEED_TRIM_EN
    logic [CNT_W-1:0] trim_last;

    assign trim_last = CNT_W'(SECTOR_CLKS - 1) + {{(CNT_W-4){speed_trim[3]}}, speed_trim};

    // Period is latched only at sector boundaries so it never changes mid-sector.
    always_ff @(posedge clk2_5 or negedge rst_n) begin
        if (!rst_n)
            p_last <= CNT_W'(SECTOR_CLKS - 1);
        else if (en && (state == IDLE || wrap))
            p_last <= trim_last;
    end
`else
    assign p_last = CNT_W'(SECTOR_CLKS - 1);
`endif

    always_comb begin
        wrap       = (cnt == p_last);
        sec_last   = (sector == SECTOR_W'(SECTORS - 1));
        rev_done   = wrap && sec_last;
        sector_nxt = sec_last ? '0 : sector + 1'b1;
        spin_done  = (state == SPINUP) && rev_done && (rev_cnt == REV_W'(SPINUP_REVS - 1));
    end

    always_ff @(posedge clk2_5 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            sector        <= '0;
            rev_cnt       <= '0;
            ready         <= 1'b0;
            sector_strobe <= 1'b0;
            index_strobe  <= 1'b0;
            sector_match  <= 1'b0;
        end else begin
            sector_strobe <= (state == READY) && (cnt < CNT_W'(STROBE_CLKS));
            index_strobe  <= (state == READY) && (cnt < CNT_W'(STROBE_CLKS)) && (sector == '0);
            sector_match  <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                cnt     <= '0;
                sector  <= '0;
                rev_cnt <= '0;
                ready   <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= SPINUP;
                    default: begin
                        if (wrap) begin
                            cnt    <= '0;
                            sector <= sector_nxt;
                            if (state == READY && sector_nxt == target_sector)
                                sector_match <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                        if (rev_done && rev_cnt != REV_W'(SPINUP_REVS))
                            rev_cnt <= rev_cnt + 1'b1;
                        // Entry edge wraps sector to 0, so a zero target matches here.
                        if (spin_done) begin
                            state        <= READY;
                            ready        <= 1'b1;
                            sector_match <= (target_sector == '0);
                        end
                    end
                endcase
            end
        end
    end

    assign at_target    = ready && (sector == target_sector);
    assign sector_phase = cnt;

endmodule
